approx_error_monitor: RTL

//  Response-side checker for exact-vs-approximate arithmetic units (adders, multipliers).
//  - Consumes paired exact and approximate results over a window of WINDOW samples.
//  - Accumulates error count, sum of absolute error and maximum absolute error.
//  - Returns the statistics through a valid/ready report handshake.
//  - Synthesizable; sits behind the stimulus driver in on-chip error-characterisation harnesses.

---
 rtl/approx_mon_pkg.sv | 22 ++
 rtl/approx_error_monitor_abs_diff.sv | 12 +
 rtl/approx_error_monitor.sv | 109 ++++++++++
 3 files changed

// File: rtl/approx_mon_pkg.sv
// Shared definitions for the approximate-arithmetic error monitor:
// FSM state encoding and a saturating accumulator helper.
package approx_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Saturating add clamped to an accumulator of 'width' bits (width <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] limit;
        sum   = {1'b0, acc} + {1'b0, inc};
        limit = (65'd1 << width) - 65'd1;
        return (sum > limit) ? limit[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/approx_error_monitor_abs_diff.sv
// Combinational unsigned magnitude |a - b|, always fits in WIDTH bits.
module abs_diff #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff
);

    assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/approx_error_monitor.sv
// Collects error statistics between exact and approximate results over a
// window of samples and hands them out through a valid/ready report port.
module approx_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int ACC_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            exact_res,
    input  logic [WIDTH-1:0]            approx_res,
    output logic                        rep_valid,
    input  logic                        rep_ready,
    output logic [$clog2(WINDOW+1)-1:0] err_count,
    output logic [ACC_W-1:0]            sum_abs_err,
    output logic [WIDTH-1:0]            max_abs_err,
    output logic                        busy
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] d1;
    logic             d1_v;
    logic             accept;
    logic [ACC_W-1:0] sum_next;

    abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
        .a    (exact_res),
        .b    (approx_res),
        .diff (diff)
    );

    assign in_ready = (state == RUN) && (sample_cnt < WIN);
    assign accept   = in_valid && in_ready;
    assign sum_next = ACC_W'(sat_add(64'(sum_abs_err), 64'(d1), ACC_W));

    // Once the last sample is in, in_ready drops, so the edge that sees
    // sample_cnt==WIN also drains stage 2: stats are final on entering REPORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            d1          <= '0;
            d1_v        <= 1'b0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            rep_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            d1_v <= accept;
            if (accept) begin
                d1         <= diff;
                sample_cnt <= sample_cnt + CNT_W'(1);
            end

            if (d1_v) begin
                if (d1 != '0) begin
                    err_count <= err_count + CNT_W'(1);
                end
                sum_abs_err <= sum_next;
                if (d1 > max_abs_err) begin
                    max_abs_err <= d1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        err_count   <= '0;
                        sum_abs_err <= '0;
                        max_abs_err <= '0;
                        sample_cnt  <= '0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (sample_cnt == WIN) begin
                        rep_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (rep_ready) begin
                        rep_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rep_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
